// File: rtl/thor2024_commit_scheduler_if.sv
// Commit-scheduler bundle: the queue-state view from the issue queue, plus the
// commit, retire and exception signals the scheduler drives back.
interface thor2024_commit_scheduler_if #(
  parameter int QENTRIES = 8,
  parameter int QBITS    = 3,
  parameter int RBITS    = 6
);
  logic [QENTRIES-1:0]       iq_v;
  logic [QENTRIES-1:0]       iq_done;
  logic [QENTRIES-1:0]       iq_rfw;
  logic [QENTRIES-1:0]       iq_exc;
  logic [QENTRIES*RBITS-1:0] iq_tgt;
  logic [QBITS-1:0]          tail0;
  logic                      stall;
  logic                      exc_ack;
  logic [QBITS-1:0]          head0;
  logic [QBITS-1:0]          head1;
  logic                      commit0_v;
  logic                      commit1_v;
  logic                      commit0_rfw;
  logic                      commit1_rfw;
  logic [RBITS-1:0]          commit0_tgt;
  logic [RBITS-1:0]          commit1_tgt;
  logic [4:0]                commit0_id;
  logic [4:0]                commit1_id;
  logic [QENTRIES-1:0]       iq_retire;
  logic                      exc_req;
  logic [QBITS-1:0]          exc_id;
  logic [31:0]               retire_cnt;

  modport master (
    output iq_v, iq_done, iq_rfw, iq_exc, iq_tgt, tail0, stall, exc_ack,
    input  head0, head1, commit0_v, commit1_v, commit0_rfw, commit1_rfw,
           commit0_tgt, commit1_tgt, commit0_id, commit1_id, iq_retire,
           exc_req, exc_id, retire_cnt
  );

  modport slave (
    input  iq_v, iq_done, iq_rfw, iq_exc, iq_tgt, tail0, stall, exc_ack,
    output head0, head1, commit0_v, commit1_v, commit0_rfw, commit1_rfw,
           commit0_tgt, commit1_tgt, commit0_id, commit1_id, iq_retire,
           exc_req, exc_id, retire_cnt
  );
endinterface

// File: rtl/thor2024_commit_scheduler.sv
// In-order dual-retire commit scheduler: picks up to two completed entries at
// the queue head, advances the head pointer and hands exceptions off.
module thor2024_commit_scheduler #(
  parameter int QENTRIES = 8,
  parameter int QBITS    = 3,
  parameter int RBITS    = 6
) (
  input logic clk,
  input logic rst,
  thor2024_commit_scheduler_if.slave bus
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_EXC = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [QBITS-1:0]    head0_r, head_nxt_s, head1_s;
  logic [QBITS-1:0]    exc_id_r, exc_id_nxt_s;
  logic                exc_req_r, exc_req_nxt_s;
  logic [31:0]         retire_cnt_r;
  logic                c0_s, c1_s;
  logic [RBITS-1:0]    tgt0_s, tgt1_s;

  assign head1_s = head0_r + QBITS'(1);
  assign tgt0_s  = bus.iq_tgt[head0_r*RBITS +: RBITS];
  assign tgt1_s  = bus.iq_tgt[head1_s*RBITS +: RBITS];

  // Commit selection and next head/state/exception values.
  always_comb begin
    c0_s          = 1'b0;
    c1_s          = 1'b0;
    head_nxt_s    = head0_r;
    state_nxt_s   = state_r;
    exc_req_nxt_s = exc_req_r;
    exc_id_nxt_s  = exc_id_r;
    case (state_r)
      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.iq_v[head0_r] && bus.iq_done[head0_r]) begin
            c0_s = 1'b1;
            if (bus.iq_exc[head0_r]) begin
              // Excepting entry retires alone; its index is handed off next cycle.
              head_nxt_s    = head0_r + QBITS'(1);
              state_nxt_s   = ST_EXC;
              exc_req_nxt_s = 1'b1;
              exc_id_nxt_s  = head0_r;
            end else if (bus.iq_v[head1_s] && bus.iq_done[head1_s] &&
                         !bus.iq_exc[head1_s] && (head1_s != bus.tail0)) begin
              c1_s       = 1'b1;
              head_nxt_s = head0_r + QBITS'(2);
            end else begin
              head_nxt_s = head0_r + QBITS'(1);
            end
          end else if (!bus.iq_v[head0_r] && (head0_r != bus.tail0)) begin
            head_nxt_s = head0_r + QBITS'(1);
          end else begin
            head_nxt_s = head0_r;
          end
        end else begin
          head_nxt_s = head0_r;
        end
      end
      ST_EXC: begin
        if (bus.exc_ack) begin
          state_nxt_s   = ST_RUN;
          exc_req_nxt_s = 1'b0;
        end else begin
          state_nxt_s   = ST_EXC;
        end
      end
      default: begin
        state_nxt_s   = ST_RUN;
        exc_req_nxt_s = 1'b0;
      end
    endcase
  end

  // Commit-side outputs; everything is forced low while reset is asserted.
  always_comb begin
    bus.commit0_v   = 1'b0;
    bus.commit1_v   = 1'b0;
    bus.commit0_rfw = 1'b0;
    bus.commit1_rfw = 1'b0;
    bus.commit0_tgt = '0;
    bus.commit1_tgt = '0;
    bus.commit0_id  = 5'd0;
    bus.commit1_id  = 5'd0;
    bus.iq_retire   = '0;
    if (!rst) begin
      bus.commit0_v   = c0_s;
      bus.commit1_v   = c1_s;
      bus.commit0_rfw = c0_s & bus.iq_rfw[head0_r] & !bus.iq_exc[head0_r] &
                        (tgt0_s != RBITS'(0));
      bus.commit1_rfw = c1_s & bus.iq_rfw[head1_s] & !bus.iq_exc[head1_s] &
                        (tgt1_s != RBITS'(0));
      bus.commit0_tgt = tgt0_s;
      bus.commit1_tgt = tgt1_s;
      bus.commit0_id  = 5'(head0_r);
      bus.commit1_id  = 5'(head1_s);
      bus.iq_retire   = (QENTRIES'(c0_s) << head0_r) | (QENTRIES'(c1_s) << head1_s);
    end else begin
      bus.iq_retire   = '0;
    end
  end

  // Head pointer, FSM state, exception hand-off and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_RUN;
      head0_r      <= '0;
      exc_req_r    <= 1'b0;
      exc_id_r     <= '0;
      retire_cnt_r <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      head0_r      <= head_nxt_s;
      exc_req_r    <= exc_req_nxt_s;
      exc_id_r     <= exc_id_nxt_s;
      retire_cnt_r <= retire_cnt_r + 32'(c0_s) + 32'(c1_s);
    end
  end

  assign bus.head0      = head0_r;
  assign bus.head1      = head1_s;
  assign bus.exc_req    = exc_req_r;
  assign bus.exc_id     = exc_id_r;
  assign bus.retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_thor2024_commit_scheduler.sv
// Self-checking bench for thor2024_commit_scheduler: directed scenarios plus a
// randomized run against an integer-arithmetic model of the retire rules.
module tb_thor2024_commit_scheduler;
  localparam int QE = 8;
  localparam int QB = 3;
  localparam int RB = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  thor2024_commit_scheduler_if #(.QENTRIES(QE), .QBITS(QB), .RBITS(RB)) ifc ();

  thor2024_commit_scheduler #(.QENTRIES(QE), .QBITS(QB), .RBITS(RB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    ifc.iq_v = '0; ifc.iq_done = '0; ifc.iq_rfw = '0; ifc.iq_exc = '0;
    ifc.iq_tgt = '0; ifc.tail0 = '0; ifc.stall = 1'b0; ifc.exc_ack = 1'b0;
  endtask

  task automatic set_ent(input int n, input logic v, input logic d, input logic w,
                         input logic e, input logic [RB-1:0] t);
    ifc.iq_v[n] = v; ifc.iq_done[n] = d; ifc.iq_rfw[n] = w; ifc.iq_exc[n] = e;
    ifc.iq_tgt[n*RB +: RB] = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    set_ent(0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd5);
    set_ent(1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd7);
    ifc.tail0 = 3'd2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({ifc.head0, ifc.exc_req, ifc.exc_id} !== 7'd0) begin
      n_fail++; $display("FAIL reset_state: got head0=%0d exc_req=%b exc_id=%0d want 0/0/0", ifc.head0, ifc.exc_req, ifc.exc_id); end
    n_cmp++; if (ifc.retire_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", ifc.retire_cnt); end
    tick();
    n_cmp++; if ({ifc.commit0_v, ifc.commit1_v, ifc.commit0_rfw, ifc.commit1_rfw, ifc.iq_retire} !== 12'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b%b rfw=%b%b retire=%b want all 0", ifc.commit0_v, ifc.commit1_v, ifc.commit0_rfw, ifc.commit1_rfw, ifc.iq_retire); end
    rst = 1'b0;
    #1;
    n_cmp++; if (ifc.commit0_v !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_commit: got %b want 1", ifc.commit0_v); end
    clear_in();
  endtask

  task automatic test_dual_commit();
    do_reset();
    set_ent(0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd5);
    set_ent(1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd7);
    ifc.tail0 = 3'd2;
    #1;
    n_cmp++; if ({ifc.commit0_v, ifc.commit1_v, ifc.commit0_rfw, ifc.commit1_rfw} !== 4'b1111) begin
      n_fail++; $display("FAIL dual_strobes: got v=%b%b rfw=%b%b want 11/11", ifc.commit0_v, ifc.commit1_v, ifc.commit0_rfw, ifc.commit1_rfw); end
    n_cmp++; if ({ifc.commit0_tgt, ifc.commit1_tgt, ifc.commit0_id, ifc.commit1_id} !== {6'd5, 6'd7, 5'd0, 5'd1}) begin
      n_fail++; $display("FAIL dual_tgt_id: got tgt %0d/%0d id %0d/%0d want 5/7 0/1", ifc.commit0_tgt, ifc.commit1_tgt, ifc.commit0_id, ifc.commit1_id); end
    n_cmp++; if (ifc.iq_retire !== 8'b00000011) begin
      n_fail++; $display("FAIL dual_retire: got %b want 00000011", ifc.iq_retire); end
    tick();
    clear_in();
    ifc.tail0 = 3'd2;
    #1;
    n_cmp++; if ({ifc.head0, ifc.retire_cnt} !== {3'd2, 32'd2}) begin
      n_fail++; $display("FAIL dual_advance: got head0=%0d cnt=%0d want 2/2", ifc.head0, ifc.retire_cnt); end
  endtask

  task automatic test_partial();
    do_reset();
    set_ent(0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd9);
    set_ent(1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd10);
    ifc.tail0 = 3'd2;
    #1;
    n_cmp++; if ({ifc.commit0_v, ifc.commit1_v, ifc.iq_retire} !== {2'b10, 8'b00000001}) begin
      n_fail++; $display("FAIL partial_single: got v=%b%b retire=%b want 10/00000001", ifc.commit0_v, ifc.commit1_v, ifc.iq_retire); end
    tick();
    set_ent(0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    #1;
    n_cmp++; if ({ifc.head0, ifc.commit0_v} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL partial_head: got head0=%0d v0=%b want 1/0", ifc.head0, ifc.commit0_v); end
    ifc.iq_done[1] = 1'b1;
    #1;
    n_cmp++; if ({ifc.commit0_v, ifc.commit0_id, ifc.commit0_tgt} !== {1'b1, 5'd1, 6'd10}) begin
      n_fail++; $display("FAIL partial_second: got v0=%b id=%0d tgt=%0d want 1/1/10", ifc.commit0_v, ifc.commit0_id, ifc.commit0_tgt); end
    tick();
    n_cmp++; if ({ifc.head0, ifc.retire_cnt} !== {3'd2, 32'd2}) begin
      n_fail++; $display("FAIL partial_cnt: got head0=%0d cnt=%0d want 2/2", ifc.head0, ifc.retire_cnt); end
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    ifc.tail0 = 3'd7;
    cyc = 0;
    while (ifc.head0 !== 3'd7 && cyc < 20) begin
      tick();
      cyc++;
    end
    n_cmp++; if ({ifc.head0, ifc.retire_cnt} !== {3'd7, 32'd0}) begin
      n_fail++; $display("FAIL wrap_reach7: got head0=%0d cnt=%0d after %0d cycles want 7/0", ifc.head0, ifc.retire_cnt, cyc); end
    set_ent(7, 1'b1, 1'b1, 1'b1, 1'b0, 6'd33);
    set_ent(0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd34);
    ifc.tail0 = 3'd1;
    #1;
    n_cmp++; if ({ifc.head1, ifc.commit0_v, ifc.commit1_v, ifc.commit0_id, ifc.commit1_id} !== {3'd0, 2'b11, 5'd7, 5'd0}) begin
      n_fail++; $display("FAIL wrap_dual: got head1=%0d v=%b%b id=%0d/%0d want 0 11 7/0", ifc.head1, ifc.commit0_v, ifc.commit1_v, ifc.commit0_id, ifc.commit1_id); end
    n_cmp++; if ({ifc.iq_retire, ifc.commit0_rfw, ifc.commit1_rfw} !== {8'b10000001, 2'b10}) begin
      n_fail++; $display("FAIL wrap_retire: got %b rfw=%b%b want 10000001 rfw=10", ifc.iq_retire, ifc.commit0_rfw, ifc.commit1_rfw); end
    tick();
    clear_in();
    ifc.tail0 = 3'd1;
    #1;
    n_cmp++; if ({ifc.head0, ifc.retire_cnt} !== {3'd1, 32'd2}) begin
      n_fail++; $display("FAIL wrap_head: got head0=%0d cnt=%0d want 1/2", ifc.head0, ifc.retire_cnt); end
  endtask

  task automatic test_exception();
    do_reset();
    set_ent(0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd3);
    set_ent(1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd4);
    ifc.tail0 = 3'd2;
    #1;
    n_cmp++; if ({ifc.commit0_v, ifc.commit0_rfw, ifc.commit1_v, ifc.iq_retire} !== {3'b100, 8'b00000001}) begin
      n_fail++; $display("FAIL exc_commit: got v0=%b rfw0=%b v1=%b retire=%b want 1/0/0/00000001", ifc.commit0_v, ifc.commit0_rfw, ifc.commit1_v, ifc.iq_retire); end
    tick();
    set_ent(0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    #1;
    n_cmp++; if ({ifc.exc_req, ifc.exc_id, ifc.head0} !== {1'b1, 3'd0, 3'd1}) begin
      n_fail++; $display("FAIL exc_req: got req=%b id=%0d head0=%0d want 1/0/1", ifc.exc_req, ifc.exc_id, ifc.head0); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({ifc.commit0_v, ifc.commit1_v, ifc.head0, ifc.exc_req} !== {2'b00, 3'd1, 1'b1}) begin
        n_fail++; $display("FAIL exc_hold_%0d: got v=%b%b head0=%0d req=%b want 00/1/1", i, ifc.commit0_v, ifc.commit1_v, ifc.head0, ifc.exc_req); end
      tick();
    end
    ifc.exc_ack = 1'b1;
    #1;
    n_cmp++; if (ifc.commit0_v !== 1'b0) begin
      n_fail++; $display("FAIL exc_ack_cycle: got v0=%b want 0", ifc.commit0_v); end
    tick();
    ifc.exc_ack = 1'b0;
    #1;
    n_cmp++; if ({ifc.exc_req, ifc.commit0_v, ifc.commit0_id} !== {2'b01, 5'd1}) begin
      n_fail++; $display("FAIL exc_resume: got req=%b v0=%b id=%0d want 0/1/1", ifc.exc_req, ifc.commit0_v, ifc.commit0_id); end
    tick();
    n_cmp++; if ({ifc.head0, ifc.retire_cnt} !== {3'd2, 32'd2}) begin
      n_fail++; $display("FAIL exc_cnt: got head0=%0d cnt=%0d want 2/2", ifc.head0, ifc.retire_cnt); end
  endtask

  task automatic test_tgt0_stall();
    do_reset();
    set_ent(0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
    ifc.tail0 = 3'd2;
    #1;
    n_cmp++; if ({ifc.commit0_v, ifc.commit0_rfw} !== 2'b10) begin
      n_fail++; $display("FAIL tgt0_rfw: got v0=%b rfw0=%b want 1/0", ifc.commit0_v, ifc.commit0_rfw); end
    tick();
    set_ent(0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    set_ent(1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd12);
    ifc.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({ifc.commit0_v, ifc.iq_retire, ifc.head0} !== {1'b0, 8'd0, 3'd1}) begin
        n_fail++; $display("FAIL stall_hold_%0d: got v0=%b retire=%b head0=%0d want 0/0/1", i, ifc.commit0_v, ifc.iq_retire, ifc.head0); end
      tick();
    end
    ifc.stall = 1'b0;
    #1;
    n_cmp++; if ({ifc.commit0_v, ifc.commit0_id, ifc.commit0_rfw} !== {1'b1, 5'd1, 1'b1}) begin
      n_fail++; $display("FAIL stall_release: got v0=%b id=%0d rfw=%b want 1/1/1", ifc.commit0_v, ifc.commit0_id, ifc.commit0_rfw); end
    tick();
    n_cmp++; if ({ifc.head0, ifc.retire_cnt} !== {3'd2, 32'd2}) begin
      n_fail++; $display("FAIL stall_cnt: got head0=%0d cnt=%0d want 2/2", ifc.head0, ifc.retire_cnt); end
  endtask

  task automatic test_bubble_rst();
    do_reset();
    set_ent(2, 1'b1, 1'b1, 1'b1, 1'b0, 6'd20);
    ifc.tail0 = 3'd3;
    #1;
    n_cmp++; if ({ifc.head0, ifc.commit0_v} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL bubble_h0: got head0=%0d v0=%b want 0/0", ifc.head0, ifc.commit0_v); end
    tick();
    n_cmp++; if ({ifc.head0, ifc.commit0_v} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL bubble_h1: got head0=%0d v0=%b want 1/0", ifc.head0, ifc.commit0_v); end
    tick();
    n_cmp++; if ({ifc.head0, ifc.commit0_v, ifc.commit0_id, ifc.retire_cnt} !== {3'd2, 1'b1, 5'd2, 32'd0}) begin
      n_fail++; $display("FAIL bubble_commit: got head0=%0d v0=%b id=%0d cnt=%0d want 2/1/2/0", ifc.head0, ifc.commit0_v, ifc.commit0_id, ifc.retire_cnt); end
    ifc.iq_exc[2] = 1'b1;
    tick();
    n_cmp++; if ({ifc.exc_req, ifc.exc_id, ifc.head0} !== {1'b1, 3'd2, 3'd3}) begin
      n_fail++; $display("FAIL bubble_exc: got req=%b id=%0d head0=%0d want 1/2/3", ifc.exc_req, ifc.exc_id, ifc.head0); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({ifc.exc_req, ifc.exc_id, ifc.head0, ifc.retire_cnt} !== {1'b0, 3'd0, 3'd0, 32'd0}) begin
      n_fail++; $display("FAIL rst_in_exc: got req=%b id=%0d head0=%0d cnt=%0d want all 0", ifc.exc_req, ifc.exc_id, ifc.head0, ifc.retire_cnt); end
    rst = 1'b0;
    clear_in();
  endtask

  task automatic test_random();
    int           mh, h1, mid;
    bit           mexc, mreq, e0, e1, r0, r1;
    logic [31:0]  mcnt;
    logic [QE-1:0] v, d, w, x, eret;
    logic [QE*RB-1:0] tg;
    logic [RB-1:0] t0, t1;
    int           tl;
    bit           st, ack;
    do_reset();
    mh = 0; mid = 0; mexc = 1'b0; mreq = 1'b0; mcnt = 32'd0;
    for (int c = 0; c < 400; c++) begin
      v = QE'($urandom); d = QE'($urandom | $urandom); w = QE'($urandom);
      for (int k = 0; k < QE; k++) x[k] = ($urandom_range(0, 9) == 0);
      tg = (QE*RB)'({$urandom, $urandom});
      tl = $urandom_range(0, QE-1);
      st = ($urandom_range(0, 4) == 0);
      ack = ($urandom_range(0, 2) == 0);
      ifc.iq_v = v; ifc.iq_done = d; ifc.iq_rfw = w; ifc.iq_exc = x; ifc.iq_tgt = tg;
      ifc.tail0 = QB'(tl); ifc.stall = st; ifc.exc_ack = ack;
      #1;
      h1 = (mh + 1) % QE;
      t0 = tg[mh*RB +: RB];
      t1 = tg[h1*RB +: RB];
      e0 = !mexc && !st && v[mh] && d[mh];
      e1 = e0 && !x[mh] && v[h1] && d[h1] && !x[h1] && (h1 != tl);
      r0 = e0 && w[mh] && !x[mh] && (t0 != 0);
      r1 = e1 && w[h1] && !x[h1] && (t1 != 0);
      eret = '0;
      if (e0) eret[mh] = 1'b1;
      if (e1) eret[h1] = 1'b1;
      n_cmp++; if ({ifc.commit0_v, ifc.commit1_v, ifc.iq_retire} !== {e0, e1, eret}) begin
        n_fail++; $display("FAIL rnd_commit c%0d: got v=%b%b retire=%b want %b%b/%b", c, ifc.commit0_v, ifc.commit1_v, ifc.iq_retire, e0, e1, eret); end
      n_cmp++; if ({ifc.commit0_v & ifc.commit0_rfw, ifc.commit1_v & ifc.commit1_rfw} !== {r0, r1}) begin
        n_fail++; $display("FAIL rnd_rfw c%0d: got %b%b want %b%b", c, ifc.commit0_rfw, ifc.commit1_rfw, r0, r1); end
      n_cmp++; if ({ifc.commit0_tgt, ifc.commit1_tgt, ifc.commit0_id, ifc.commit1_id, ifc.head1} !== {t0, t1, 5'(mh), 5'(h1), QB'(h1)}) begin
        n_fail++; $display("FAIL rnd_sel c%0d: got tgt %0d/%0d id %0d/%0d head1 %0d want %0d/%0d %0d/%0d %0d", c, ifc.commit0_tgt, ifc.commit1_tgt, ifc.commit0_id, ifc.commit1_id, ifc.head1, t0, t1, mh, h1, h1); end
      mcnt = mcnt + 32'(e0) + 32'(e1);
      if (mexc) begin
        if (ack) begin mexc = 1'b0; mreq = 1'b0; end
      end else if (e0 && x[mh]) begin
        mexc = 1'b1; mreq = 1'b1; mid = mh; mh = (mh + 1) % QE;
      end else if (e0) begin
        mh = (mh + 1 + int'(e1)) % QE;
      end else if (!st && !v[mh] && mh != tl) begin
        mh = (mh + 1) % QE;
      end
      tick();
      n_cmp++; if ({ifc.head0, ifc.exc_req, ifc.exc_id, ifc.retire_cnt} !== {QB'(mh), mreq, QB'(mid), mcnt}) begin
        n_fail++; $display("FAIL rnd_state c%0d: got head0=%0d req=%b id=%0d cnt=%0d want %0d/%b/%0d/%0d", c, ifc.head0, ifc.exc_req, ifc.exc_id, ifc.retire_cnt, mh, mreq, mid, mcnt); end
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_dual_commit();
    test_partial();
    test_wrap();
    test_exception();
    test_tgt0_stall();
    test_bubble_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/thor2024_commit_scheduler.md
Name: thor2024_commit_scheduler

Overview:
- Selects up to two completed instructions per cycle from the head of the instruction queue and retires them in order.
- Drives the commit0/commit1 strobes, targets and ids consumed by the register-file valid/source tracking logic and the register file write ports.
- Owns the queue head pointer, the retire counter and the exception hand-off.
- Sits between the issue queue and the register file / exception unit.

Parameters:
- QENTRIES, 8, number of queue entries; power of two.
- QBITS, 3, log2(QENTRIES).
- RBITS, 6, architectural register specifier width (64 registers).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- iq_v  in  QENTRIES  entry valid
- iq_done  in  QENTRIES  entry result ready
- iq_rfw  in  QENTRIES  entry writes register file
- iq_exc  in  QENTRIES  entry raised exception
- iq_tgt  in  QENTRIES*RBITS  entry target; entry n occupies bits [n*RBITS +: RBITS]
- tail0  in  QBITS  queue tail (next enqueue slot)
- stall  in  1  external commit hold
- exc_ack  in  1  exception unit accepted exc_req
- head0  out  QBITS  oldest entry index
- head1  out  QBITS  head0+1 mod QENTRIES
- commit0_v, commit1_v  out  1 each  commit strobes
- commit0_rfw, commit1_rfw  out  1 each  commit writes register file
- commit0_tgt, commit1_tgt  out  RBITS each  commit targets
- commit0_id, commit1_id  out  5 each  queue index zero-extended to 5 bits
- iq_retire  out  QENTRIES  one-hot-or-two mask of entries retired this cycle
- exc_req  out  1  exception pending to exception unit
- exc_id  out  QBITS  queue index of excepting entry
- retire_cnt  out  32  instructions retired, wraps

Behaviour:
- Reset, asynchronous, immediate and also mid-operation: state=RUN, head0=0, exc_req=0, exc_id=0, retire_cnt=0.
- While rst is high, all commit outputs and iq_retire are 0.
- The FSM has two states, RUN and EXC.
- commit* outputs and iq_retire are combinational from the registered head0/state and the current iq inputs. head0, retire_cnt and state update on the next clk edge, so zero-cycle commit and one-cycle pointer advance.
- RUN, no stall, commit0 condition: iq_v[head0] & iq_done[head0].
- RUN, no stall, commit1 condition: commit0 & iq_v[head1] & iq_done[head1] & !iq_exc[head0] & !iq_exc[head1] & head1!=tail0.
- commitN_rfw = iq_rfw[entry] & !iq_exc[entry] & (tgt != 0); register 0 is never written.
- commitN_tgt and commitN_id are driven from the selected entry even when not committing; they are qualified only by commitN_v.
- Head advance: +2 if both commit, +1 if commit0 only, all mod QENTRIES.
- Bubble skip: if !iq_v[head0] and head0!=tail0, advance +1 with no commit. Empty queue (head0==tail0 and !iq_v[head0]): hold.
- Exception: if commit0 and iq_exc[head0], then commit0_v=1, commit0_rfw=0, commit1_v=0, head advances +1. Next cycle: state=EXC, exc_req=1, exc_id=old head0.
- EXC: no commits, no bubble skip, head held. On exc_ack: exc_req cleared next edge and state returns to RUN. exc_ack in RUN is ignored.
- stall=1 suppresses commits and bubble skip (head held). Stall has no effect on the EXC handshake.
- retire_cnt += commit0_v + commit1_v each edge, wraps at 2^32.
- Same target on both commits: both strobes are still asserted. Resolution is by the downstream valid-tracking logic.
- Head wrap: at head0=QENTRIES-1, head1=0 and a dual commit yields head0=1.

Test Plan:
- Reset then entries 0,1 valid+done, rfw, tgt 5 and 7, tail0=2 → same cycle commit0_v=commit1_v=1, tgt 5/7, id 0/1, iq_retire=8'b00000011; next cycle head0=2, retire_cnt=2.
- Entry 0 done, entry 1 not done → only commit0_v; head0=1. Make entry 1 done → commit0_id=1; retire_cnt=2.
- head0=7, entries 7 and 0 done → dual commit, head1=0, head0 becomes 1.
- Entry 0 with iq_exc=1 and entry 1 done → commit0_v=1, commit0_rfw=0, commit1_v=0. Next cycle exc_req=1, exc_id=0, no commits for 5 cycles. Pulse exc_ack → exc_req=0 next edge, then entry 1 commits.
- Entry 0 rfw with tgt 0 → commit0_v=1, commit0_rfw=0. Then stall=1 with entry 1 done → no commit and head held until stall=0.
- Entries 0,1 invalid, tail0=3, entry 2 done → head skips 0→1→2 over two cycles, then commit0_id=2. Assert rst while in EXC → exc_req=0, head0=0 immediately.
